// File: rtl/ysyx_ifu_pkg.sv
// Shared types for the NPC instruction fetch unit.
// IFU_MISALIGN_CHK_EN adds the FAULT state for misaligned next-PC values.
package ysyx_ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

`ifdef IFU_MISALIGN_CHK_EN
  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_EXEC  = 3'd4,
    ST_FAULT = 3'd5
  } ifu_state_e;
`else
  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_EXEC  = 3'd4
  } ifu_state_e;
`endif

  // Instruction memory is word addressed; the low two bits never reach the bus.
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_ysyx_if.sv
// Bundle of the next-PC, AXI-lite read and decoder handshakes around the IFU.
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
interface ifu_fetch_ysyx_if;
  import ysyx_ifu_pkg::*;

  logic [31:0] npc;
  logic        npc_valid;
  logic [31:0] pc;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        ifu_fault;
  ifu_state_e  fsm_state;

  modport master (
    input  npc, npc_valid, arready, rdata, rresp, rvalid, inst_ready,
    output pc, araddr, arvalid, rready, inst, inst_valid, ifu_fault, fsm_state
  );

  modport slave (
    output npc, npc_valid, arready, rdata, rresp, rvalid, inst_ready,
    input  pc, araddr, arvalid, rready, inst, inst_valid, ifu_fault, fsm_state
  );

endinterface

// File: rtl/ifu_fetch_ysyx.sv
// NPC instruction fetch: owns the PC, issues one read per instruction, hands it to decode.
// IFU_MISALIGN_CHK_EN traps misaligned next-PC values into a sticky FAULT state.
module ifu_fetch_ysyx
  import ysyx_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  ifu_fetch_ysyx_if.master  bus
);

  ifu_state_e  state, state_next;
  logic [31:0] pc_q, pc_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] inst_q, inst_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fault_q, fault_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_BOOT;
      pc_q         <= RESET_PC;
      araddr_q     <= RESET_PC;
      inst_q       <= 32'h0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state        <= state_next;
      pc_q         <= pc_d;
      araddr_q     <= araddr_d;
      inst_q       <= inst_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
    end
  end

  // Next values are computed here so every output leaves a flop.
  always_comb begin
    state_next   = state;
    pc_d         = pc_q;
    araddr_d     = araddr_q;
    inst_d       = inst_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    inst_valid_d = inst_valid_q;
    fault_d      = fault_q;
    case (state)
      ST_BOOT: begin
        state_next = ST_REQ;
        arvalid_d  = 1'b1;
        araddr_d   = word_addr(pc_q);
      end
      ST_REQ: begin
        // rvalid is not looked at here: data cannot precede the address handshake.
        if (bus.arready) begin
          state_next = ST_WAIT;
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.rvalid) begin
          state_next   = ST_HOLD;
          rready_d     = 1'b0;
          inst_d       = bus.rdata;
          inst_valid_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.inst_ready) begin
          state_next   = ST_EXEC;
          inst_valid_d = 1'b0;
        end
      end
      ST_EXEC: begin
        if (bus.npc_valid) begin
          pc_d = bus.npc;
`ifdef IFU_MISALIGN_CHK_EN
          if (bus.npc[1:0] != 2'b00) begin
            state_next = ST_FAULT;
            fault_d    = 1'b1;
          end else
`endif
          begin
            state_next = ST_REQ;
            arvalid_d  = 1'b1;
            araddr_d   = word_addr(bus.npc);
          end
        end
      end
`ifdef IFU_MISALIGN_CHK_EN
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
`endif
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  // The read response code carries no information the core acts on.
  logic unused_rresp;
  assign unused_rresp = ^bus.rresp;

  assign bus.pc         = pc_q;
  assign bus.araddr     = araddr_q;
  assign bus.arvalid    = arvalid_q;
  assign bus.rready     = rready_q;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.fsm_state  = state;
`ifdef IFU_MISALIGN_CHK_EN
  assign bus.ifu_fault  = fault_q;
`else
  assign bus.ifu_fault  = 1'b0;
  logic unused_fault;
  assign unused_fault = fault_q ^ fault_d;
`endif

endmodule
